// File: rtl/prbs9_pkg.sv
// Shared definitions for the PRBS9 (x^9 + x^5 + 1) generator/checker pair.
// Tap constants live here so both ends of the link agree on the polynomial.
package prbs9_pkg;

    localparam int PRBS_ORDER = 9;
    localparam int PRBS_TAP   = 5;

    typedef enum logic [1:0] {
        FILL,
        SEARCH,
        LOCKED
    } state_t;

    // b[n] = b[n-9] ^ b[n-5], with h[0] holding the newest bit
    function automatic logic prbs9_next(input logic [PRBS_ORDER-1:0] h);
        return h[PRBS_ORDER-1] ^ h[PRBS_TAP-1];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prbs9_checker.sv
// Self-synchronising PRBS9 bit-error checker with flywheel reference and
// windowed loss-of-sync detection.
//
//   state  | meaning
//   FILL   | loading 9 received bits into the history register
//   SEARCH | counting consecutive correct predictions towards lock
//   LOCKED | free-running reference, counting bits and errors
module prbs9_checker
    import prbs9_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int WINDOW     = 64,
    parameter int LOS_THRESH = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_bit_count
);

    localparam int SEQ_MAX = (LOCK_COUNT > PRBS_ORDER) ? LOCK_COUNT : PRBS_ORDER;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);

    state_t                state, state_n;
    logic [PRBS_ORDER-1:0] h, h_n;
    logic [SEQ_W-1:0]      seq_cnt, seq_n;
    logic [WIN_W-1:0]      win_bits, win_bits_n;
    logic [WIN_W-1:0]      win_errs, win_errs_n, win_errs_sum;
    logic                  locked_n, error_n;
    logic                  bit_inc, err_inc;
    logic                  pred, mismatch;

    assign pred         = prbs9_next(h);
    assign mismatch     = i_bit ^ pred;
    assign win_errs_sum = win_errs + WIN_W'(mismatch);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= FILL;
            h        <= '0;
            seq_cnt  <= '0;
            win_bits <= '0;
            win_errs <= '0;
            o_locked <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            state    <= state_n;
            h        <= h_n;
            seq_cnt  <= seq_n;
            win_bits <= win_bits_n;
            win_errs <= win_errs_n;
            o_locked <= locked_n;
            o_error  <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        h_n        = h;
        seq_n      = seq_cnt;
        win_bits_n = win_bits;
        win_errs_n = win_errs;
        error_n    = 1'b0;
        bit_inc    = 1'b0;
        err_inc    = 1'b0;
        if (i_enable) begin
            case (state)
                FILL: begin
                    h_n = {h[PRBS_ORDER-2:0], i_bit};
                    if (seq_cnt == SEQ_W'(PRBS_ORDER - 1)) begin
                        state_n = SEARCH;
                        seq_n   = '0;
                    end else begin
                        seq_n = seq_cnt + SEQ_W'(1);
                    end
                end
                SEARCH: begin
                    h_n = {h[PRBS_ORDER-2:0], i_bit};
                    if (mismatch) begin
                        seq_n = '0;
                    end else if (seq_cnt == SEQ_W'(LOCK_COUNT - 1)) begin
                        state_n    = LOCKED;
                        seq_n      = '0;
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end else begin
                        seq_n = seq_cnt + SEQ_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: feed back the prediction so line errors never reach h
                    h_n     = {h[PRBS_ORDER-2:0], pred};
                    bit_inc = 1'b1;
                    err_inc = mismatch;
                    error_n = mismatch;
                    if (win_bits == WIN_W'(WINDOW - 1)) begin
                        if (win_errs_sum >= WIN_W'(LOS_THRESH)) begin
                            state_n = FILL;
                            seq_n   = '0;
                        end
                        win_bits_n = '0;
                        win_errs_n = '0;
                    end else begin
                        win_bits_n = win_bits + WIN_W'(1);
                        win_errs_n = win_errs_sum;
                    end
                end
                default: state_n = FILL;
            endcase
        end
        locked_n = (state_n == LOCKED);
    end

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clock   (clock),
        .reset_n (i_reset),
        .inc     (bit_inc),
        .clear   (i_clear),
        .count   (o_bit_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock   (clock),
        .reset_n (i_reset),
        .inc     (err_inc),
        .clear   (i_clear),
        .count   (o_err_count)
    );

endmodule

// File: tb/tb_prbs9_checker.sv
// Scoreboard bench for prbs9_checker: a default instance (a) and a
// small-counter, high-threshold instance (b) for saturation and reset.
module tb_prbs9_checker;

    localparam int LOCK_COUNT = 16;
    localparam int WINDOW     = 64;

    logic        clock = 1'b0;
    logic        rst_a = 1'b0, en_a = 1'b0, bit_a = 1'b0, clr_a = 1'b0;
    logic        locked_a, error_a;
    logic [31:0] errc_a, bitc_a;
    logic        rst_b = 1'b0, en_b = 1'b0, bit_b = 1'b0, clr_b = 1'b0;
    logic        locked_b, error_b;
    logic [3:0]  errc_b, bitc_b;

    always #5 clock = ~clock;

    prbs9_checker dut_a (
        .clock       (clock),
        .i_reset     (rst_a),
        .i_enable    (en_a),
        .i_bit       (bit_a),
        .i_clear     (clr_a),
        .o_locked    (locked_a),
        .o_error     (error_a),
        .o_err_count (errc_a),
        .o_bit_count (bitc_a)
    );

    prbs9_checker #(.CNT_W(4), .LOS_THRESH(64)) dut_b (
        .clock       (clock),
        .i_reset     (rst_b),
        .i_enable    (en_b),
        .i_bit       (bit_b),
        .i_clear     (clr_b),
        .o_locked    (locked_b),
        .o_error     (error_b),
        .o_err_count (errc_b),
        .o_bit_count (bitc_b)
    );

    typedef struct {
        int     acq;
        bit     locked;
        int     wbits;
        int     werrs;
        longint bitc;
        longint errc;
        bit     err;
    } model_t;

    typedef struct {
        int     which;
        bit     locked;
        bit     err;
        longint bitc;
        longint errc;
    } exp_t;

    model_t   ma, mb, mzero;
    exp_t     sb[$];
    logic [8:0] gen = 9'h1AA;
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit prbs_next();
        bit nb;
        nb  = gen[8] ^ gen[4];
        gen = {gen[7:0], nb};
        return nb;
    endfunction

    // Behavioural reference: uses the known injected-error flag rather than a history register
    function automatic model_t model_step(model_t m, bit en, bit flip, bit clr,
                                          longint cmax, int los);
        model_t n;
        n     = m;
        n.err = 1'b0;
        if (en) begin
            if (!m.locked) begin
                n.acq = m.acq + 1;
                if (n.acq == 9 + LOCK_COUNT) begin
                    n.locked = 1'b1;
                    n.wbits  = 0;
                    n.werrs  = 0;
                end
            end else begin
                n.err = flip;
                if (m.bitc < cmax) n.bitc = m.bitc + 1;
                if (flip && m.errc < cmax) n.errc = m.errc + 1;
                n.wbits = m.wbits + 1;
                n.werrs = m.werrs + int'(flip);
                if (n.wbits == WINDOW) begin
                    if (n.werrs >= los) begin
                        n.locked = 1'b0;
                        n.acq    = 0;
                    end
                    n.wbits = 0;
                    n.werrs = 0;
                end
            end
        end
        if (clr) begin
            n.bitc = 0;
            n.errc = 0;
        end
        return n;
    endfunction

    task automatic drive(input int which, input bit en, input bit flip, input bit clr);
        model_t m;
        exp_t   e;
        bit     feff, b;
        @(negedge clock);
        m    = (which == 0) ? ma : mb;
        feff = flip && en && m.locked;
        if (en) b = prbs_next() ^ feff;
        else    b = 1'($urandom_range(0, 1));
        if (which == 0) begin
            en_a = en; bit_a = b; clr_a = clr; en_b = 1'b0; clr_b = 1'b0;
            m = model_step(m, en, feff, clr, 64'hFFFF_FFFF, 8);
            ma = m;
        end else begin
            en_b = en; bit_b = b; clr_b = clr; en_a = 1'b0; clr_a = 1'b0;
            m = model_step(m, en, feff, clr, 15, 64);
            mb = m;
        end
        e.which = which; e.locked = m.locked; e.err = m.err; e.bitc = m.bitc; e.errc = m.errc;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        if (e.which == 0) begin
            check("a_locked", longint'(locked_a), longint'(e.locked));
            check("a_error",  longint'(error_a),  longint'(e.err));
            check("a_bitc",   longint'(bitc_a),   e.bitc);
            check("a_errc",   longint'(errc_a),   e.errc);
        end else begin
            check("b_locked", longint'(locked_b), longint'(e.locked));
            check("b_error",  longint'(error_b),  longint'(e.err));
            check("b_bitc",   longint'(bitc_b),   e.bitc);
            check("b_errc",   longint'(errc_b),   e.errc);
        end
    endtask

    task automatic align_a();
        for (int i = 0; i < WINDOW && ma.wbits != 0; i++) drive(0, 1'b1, 1'b0, 1'b0);
        check("a_align", longint'(ma.wbits), 0);
    endtask

    initial begin
        mzero = '{acq: 0, locked: 1'b0, wbits: 0, werrs: 0, bitc: 0, errc: 0, err: 1'b0};
        ma = mzero;
        mb = mzero;
        #1;
        check("rst_locked", longint'(locked_a), 0);
        check("rst_error",  longint'(error_a),  0);
        check("rst_bitc",   longint'(bitc_a),   0);
        check("rst_errc",   longint'(errc_a),   0);
        repeat (3) @(negedge clock);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // clean lock on bit 25, then 1000 clean bits
        for (int i = 0; i < 24; i++) drive(0, 1'b1, 1'b0, 1'b0);
        check("lock_bit24", longint'(locked_a), 0);
        drive(0, 1'b1, 1'b0, 1'b0);
        check("lock_bit25", longint'(locked_a), 1);
        for (int i = 0; i < 1000; i++) drive(0, 1'b1, 1'b0, 1'b0);
        check("clean_bitc", longint'(bitc_a), 1000);
        check("clean_errc", longint'(errc_a), 0);

        // single flip
        drive(0, 1'b1, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b1, 1'b0);
        check("flip_pulse", longint'(error_a), 1);
        for (int i = 0; i < 100; i++) drive(0, 1'b1, 1'b0, 1'b0);
        check("flip_errc",   longint'(errc_a),   1);
        check("flip_locked", longint'(locked_a), 1);

        // 8 errors in one window -> loss at window end, relock 25 bits later
        align_a();
        for (int i = 0; i < WINDOW; i++) drive(0, 1'b1, (i % 8) == 0, 1'b0);
        check("los_drop", longint'(locked_a), 0);
        for (int i = 0; i < 25; i++) drive(0, 1'b1, 1'b0, 1'b0);
        check("los_relock", longint'(locked_a), 1);

        // 7 errors per window keeps lock
        drive(0, 1'b1, 1'b0, 1'b1);
        align_a();
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < WINDOW; i++) drive(0, 1'b1, (i % 9) == 0 && i < 63, 1'b0);
        check("below_errc",   longint'(errc_a),   21);
        check("below_locked", longint'(locked_a), 1);

        // random enable duty with sparse errors, then clear coinciding with an error
        for (int i = 0; i < 600; i++)
            drive(0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0, 1'b0);
        drive(0, 1'b1, 1'b1, 1'b1);
        check("clr_bitc", longint'(bitc_a), 0);
        check("clr_errc", longint'(errc_a), 0);

        // instance b: saturation with a 30-bit error burst
        for (int i = 0; i < 25; i++) drive(1, 1'b1, 1'b0, 1'b0);
        check("b_lock", longint'(locked_b), 1);
        for (int i = 0; i < 30; i++) drive(1, 1'b1, 1'b1, 1'b0);
        check("sat_errc",   longint'(errc_b),   15);
        check("sat_locked", longint'(locked_b), 1);

        // asynchronous reset mid-lock
        @(negedge clock);
        #2 rst_b = 1'b0;
        #1;
        mb = mzero;
        check("areset_locked", longint'(locked_b), 0);
        check("areset_error",  longint'(error_b),  0);
        check("areset_errc",   longint'(errc_b),   0);
        check("areset_bitc",   longint'(bitc_b),   0);
        @(negedge clock);
        rst_b = 1'b1;
        for (int i = 0; i < 40; i++) drive(1, 1'b1, 1'b0, 1'b0);
        check("relock_b", longint'(locked_b), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
